// File: rtl/tdm_pkg.sv
// tdm_pkg: state encoding and shared constants for the TDM mux/demux slot logic
package tdm_pkg;
  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_e;
  localparam int N_DEF     = 4;
  localparam int W_DEF     = 1;
  localparam int ERR_CNT_W = 8;
  localparam int ERR_LIMIT = 3;
endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: SW-bit slot index with increment, load-to-1 and clear; wrap_o flags slot N-1
// Ports: clk, rst_n (async active-low), inc_i, load1_i, clr_i (priority clr > load1 > inc),
//        slot_o current slot, wrap_o high while slot_o == N-1
module tdm_slot_counter import tdm_pkg::*; #(
  parameter int N = N_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          wrap_o
);
  logic [SW-1:0] slot_q, slot_d;
  // N is a power of two, so the increment wraps N-1 -> 0 on its own
  always_comb slot_d = clr_i ? '0 : load1_i ? SW'(1) : inc_i ? slot_q + SW'(1) : slot_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) slot_q <= '0;
    else slot_q <= slot_d;
  assign slot_o = slot_q;
  assign wrap_o = slot_q == SW'(N - 1);
endmodule

// File: rtl/tdm_demux.sv
// tdm_demux: rebuilds N parallel W-bit lanes from a frame_sync-aligned TDM sample stream
// Ports: clk, rst_n (async active-low); din/din_valid/frame_sync serial input;
//        dout last complete frame (lane k at [k*W +: W]), frame_valid 1-cycle update strobe,
//        slot next write index, locked in LOCKED state, sync_err 1-cycle misplaced-sync pulse.
// Option TDM_ERR_CNT_EN: adds err_cnt (saturating sync_err count); the 4th consecutive
//        sync_err without a completed frame in between drops back to HUNT.
module tdm_demux import tdm_pkg::*; #(
  parameter int W = W_DEF,
  parameter int N = N_DEF,
  localparam int SW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
  output logic [N*W-1:0]       dout,
  output logic                 frame_valid,
  output logic [SW-1:0]        slot,
  output logic                 locked,
  output logic                 sync_err
`ifdef TDM_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
  state_e                state_q, state_d;
  logic [N-1:0][W-1:0]   shadow_q, shadow_d, dout_q, dout_d;
  logic                  fv_q, fv_d, se_q, se_d;
  logic                  inc, ld, clr, wrap, limit_hit;
  tdm_slot_counter #(.N(N)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (inc),
    .load1_i (ld),
    .clr_i   (clr),
    .slot_o  (slot),
    .wrap_o  (wrap)
  );
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    se_d     = 1'b0;
    inc      = 1'b0;
    ld       = 1'b0;
    clr      = 1'b0;
    if (din_valid) begin
      if (state_q == HUNT) begin
        if (frame_sync) begin
          shadow_d[0] = din;
          ld          = 1'b1;
          state_d     = LOCKED;
        end
      end else if (frame_sync && slot != '0) begin
        // misplaced sync: drop the partial frame and restart at slot 0 with this sample
        se_d = 1'b1;
        if (limit_hit) begin
          state_d = HUNT;
          clr     = 1'b1;
        end else begin
          shadow_d[0] = din;
          ld          = 1'b1;
        end
      end else begin
        shadow_d[slot] = din;
        inc            = 1'b1;
        if (wrap) begin
          dout_d = shadow_d;
          fv_d   = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= HUNT;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      se_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      se_q     <= se_d;
    end
`ifdef TDM_ERR_CNT_EN
  localparam int CW = $clog2(ERR_LIMIT + 1);
  logic [CW-1:0]        consec_q, consec_d;
  logic [ERR_CNT_W-1:0] ec_q, ec_d;
  assign limit_hit = consec_q == CW'(ERR_LIMIT);
  // consecutive-error run restarts on any completed frame or on losing lock
  always_comb begin
    consec_d = (fv_d || state_d == HUNT) ? '0 : se_d ? consec_q + CW'(1) : consec_q;
    ec_d     = (se_d && ec_q != '1) ? ec_q + ERR_CNT_W'(1) : ec_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      consec_q <= '0;
      ec_q     <= '0;
    end else begin
      consec_q <= consec_d;
      ec_q     <= ec_d;
    end
  assign err_cnt = ec_q;
`else
  assign limit_hit = 1'b0;
`endif
  assign dout        = dout_q;
  assign frame_valid = fv_q;
  assign locked      = state_q == LOCKED;
  assign sync_err    = se_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux with a queue-based frame-assembly reference model
module tb_tdm_demux;
  localparam int N  = 4;
  localparam int W  = 1;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_valid = 1'b0;
  logic           frame_sync = 1'b0;
  logic [N*W-1:0] dout;
  logic           frame_valid;
  logic [SW-1:0]  slot;
  logic           locked;
  logic           sync_err;
`ifdef TDM_ERR_CNT_EN
  logic [7:0]     err_cnt;
`endif

  tdm_demux #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .dout        (dout),
    .frame_valid (frame_valid),
    .slot        (slot),
    .locked      (locked),
    .sync_err    (sync_err)
`ifdef TDM_ERR_CNT_EN
    ,
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {int stamp; bit locked; int slot; logic [N*W-1:0] dout; int ec;} st_t;
  typedef struct {int stamp; logic [1:0] kind;} ev_t;  // kind = {sync_err, frame_valid}
  st_t st_q[$];
  ev_t ev_q[$];

  // reference model: a frame is simply the list of samples gathered since slot 0
  bit           m_locked = 0;
  logic [W-1:0] cur[$];
  logic [N*W-1:0] m_dout = '0;
  int           m_consec = 0;
  int           m_ec = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    cur.delete();
    m_dout = '0;
    m_consec = 0;
    m_ec = 0;
  endtask

  task automatic model_step(bit s, logic [W-1:0] d);
    if (!m_locked) begin
      if (s) begin
        cur = {d};
        m_locked = 1;
      end
    end else if (s && cur.size() != 0) begin
      ev_q.push_back('{cyc + 1, 2'b10});
`ifdef TDM_ERR_CNT_EN
      if (m_ec < 255) m_ec++;
      m_consec++;
      if (m_consec > 3) begin
        m_locked = 0;
        m_consec = 0;
        cur.delete();
      end else cur = {d};
`else
      cur = {d};
`endif
    end else begin
      cur.push_back(d);
      if (cur.size() == N) begin
        for (int k = 0; k < N; k++) m_dout[k*W +: W] = cur[k];
        ev_q.push_back('{cyc + 1, 2'b01});
        cur.delete();
        m_consec = 0;
      end
    end
  endtask

  task automatic push_status();
    st_q.push_back('{cyc + 1, m_locked, cur.size(), m_dout, m_ec});
  endtask

  task automatic drive(bit v, bit s, logic [W-1:0] d);
    @(negedge clk);
    rst_n      = 1'b1;
    din_valid  = v;
    frame_sync = s;
    din        = d;
    if (v) model_step(s, d);
    push_status();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    model_reset();
    push_status();
  endtask

  // monitor: compares status every cycle and pops an expected event whenever a strobe appears
  st_t s;
  initial forever begin
    @(posedge clk);
    #1;
    if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
      s = st_q.pop_front();
      chk("locked", int'(locked), int'(s.locked));
      chk("slot", int'(slot), s.slot);
      chk("dout", int'(dout), int'(s.dout));
`ifdef TDM_ERR_CNT_EN
      chk("err_cnt", int'(err_cnt), s.ec);
`endif
    end
    while (ev_q.size() > 0 && ev_q[0].stamp < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_strobe: got none expected kind %0d at cycle %0d", ev_q[0].kind, ev_q[0].stamp);
      void'(ev_q.pop_front());
    end
    if (frame_valid || sync_err) begin
      checks++;
      if (ev_q.size() == 0 || ev_q[0].stamp != cyc || ev_q[0].kind != {sync_err, frame_valid}) begin
        errors++;
        $display("FAIL unexpected_strobe: got {se,fv}=%b expected none at cycle %0d", {sync_err, frame_valid}, cyc);
      end else void'(ev_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();
    // unsynced samples while hunting are dropped
    drive(1, 0, 1); drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 1);
    // synced frame, back to back
    drive(1, 1, 1); drive(1, 0, 0); drive(1, 0, 0); drive(1, 0, 1);
    // same frame with gaps (sync on idle cycles is ignored)
    drive(1, 1, 1); drive(0, 1, 0); drive(1, 0, 0); drive(0, 0, 1);
    drive(1, 0, 0); drive(0, 1, 1); drive(1, 0, 1);
    // misplaced sync at slot 2, then frame 0,1,1,0
    drive(1, 0, 1); drive(1, 0, 1); drive(1, 1, 0); drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 0);
    // reset mid-frame, then unsynced samples dropped
    drive(1, 1, 1); drive(1, 0, 1); do_reset();
    drive(1, 0, 1); drive(1, 0, 1); drive(1, 0, 0);
`ifdef TDM_ERR_CNT_EN
    drive(1, 1, 1);
    repeat (4) drive(1, 1, 0);
    drive(1, 0, 1); drive(1, 0, 1);
`endif
    // random traffic
    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 299);
      if (r == 0) do_reset();
      else drive($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 12, W'($urandom_range(0, (1 << W) - 1)));
    end
    repeat (3) drive(0, 0, 0);
    @(posedge clk);
    #2;
    chk("leftover_events", ev_q.size(), 0);
    chk("leftover_status", st_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of a time-division-multiplexed link: a 4:1 multiplexer driven by a slot counter serialises lanes onto one wire; this block rebuilds the lanes.
- Captures one W-bit sample per valid cycle into the lane register selected by an internal slot counter, aligned by frame_sync.
- Presents a complete parallel frame with a one-cycle strobe.
- Sits between the serial link input and downstream parallel consumers.

Parameters:
- W, 1, sample width per lane (bits)
- N, 4, lanes per frame; power of two, N >= 2
- SW, 2, slot index width = log2(N); derived, do not override

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- din  input  W  serial sample for the current slot
- din_valid  input  1  din carries a sample this cycle
- frame_sync  input  1  marks din as slot 0; qualified by din_valid
- dout  output  N*W  last complete frame; lane k at [k*W +: W]
- frame_valid  output  1  one-cycle pulse when dout is updated
- slot  output  SW  index the next valid sample will be written to
- locked  output  1  high in LOCKED state
- sync_err  output  1  one-cycle pulse when frame_sync arrives at slot != 0

Behaviour:
- Reset (async assert, sync release): dout=0, frame_valid=0, slot=0, locked=0, sync_err=0, shadow lanes=0, state=HUNT.
- No action in either state when din_valid=0; frame_sync without din_valid is ignored.
- HUNT state:
  - Valid samples without sync are dropped.
  - valid&sync: shadow[0]<=din, slot<=1, go to LOCKED.
- LOCKED state:
  - valid&!sync: shadow[slot]<=din, slot<=slot+1 (wraps N-1 -> 0).
  - valid&sync at slot==0: normal slot-0 capture.
  - valid&sync at slot!=0: sync_err=1 next cycle; partial frame discarded (no frame_valid); din taken as slot 0, slot<=1; stays LOCKED.
  - Sync is optional after lock: a slot-0 sample without sync is accepted (free-running).
- Frame completion:
  - The capture edge of slot N-1 loads dout with shadow[0..N-2] plus the new din.
  - frame_valid is high for exactly the following cycle (latency 1 from the last sample).
  - dout holds until the next complete frame.
- Back-to-back frames: frame_valid may assert every N valid cycles; valid gaps only stretch the frame.
- Reset mid-frame: everything is cleared and the block returns to HUNT; the partial frame is lost.
- sync_err and frame_valid are never high in the same cycle.

Optional Feature:
- Macro: TDM_ERR_CNT_EN
- Defined:
  - Extra output err_cnt [7:0]: saturating count of sync_err pulses; holds at 255.
  - Cleared by reset only.
  - A 4th consecutive sync_err without an intervening complete frame drops locked to HUNT.
- Undefined: no err_cnt port; sync_err never forces HUNT.

Decomposition:
- Shared package/include tdm_pkg:
  - state encoding HUNT=1'b0, LOCKED=1'b1
  - default N and W constants
  - ERR_CNT_W=8, ERR_LIMIT=3
- Shared with the transmit-side mux slot counter.
- One sub-module: tdm_slot_counter (SW-bit counter with increment, load-to-1 and clear inputs, wrap flag at N-1).

Test Plan:
- Reset, then valid samples 1,0,0,1 with no sync -> stays HUNT; locked=0, frame_valid never 1, dout=4'b0000.
- sync+valid with 1,0,0,1 on consecutive cycles (W=1) -> locked=1 after the first edge; frame_valid pulse 1 cycle after the 4th sample; dout=4'b1001; slot back to 0.
- Same frame with din_valid low between every sample -> identical dout=4'b1001; single frame_valid pulse, delayed by the gaps.
- Locked, samples 1,1 then sync with din=0 at slot 2 -> sync_err pulse; no frame_valid; frame 0,1,1,0 then completes with dout=4'b0110.
- rst_n low for 1 cycle after 2 samples of a frame -> all outputs 0, HUNT; the next unsynced samples are dropped.
- With TDM_ERR_CNT_EN defined, 4 consecutive misplaced syncs -> err_cnt=4, locked=0 after the 4th.
